// File: rtl/eq_pkg.sv
// Shared constants, register map and FSM state type for the equaliser
// gain/mix stage.
package eq_pkg;

    localparam int NBANDS = 10;
    localparam int DW     = 16;
    localparam int GW     = 8;

    localparam logic [3:0] GAIN0_OFS = 4'd0;
    localparam logic [3:0] CTRL_OFS  = 4'd10;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_SAT = 1;
    localparam int CTRL_OVR = 2;

    // Q4.4 unity gain
    localparam logic [GW-1:0] GAIN_RESET = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_ROUND,
        ST_OUT
    } mix_state_t;

endpackage

// File: rtl/band_gain_regs.sv
// APB register file for band_gain_mixer: per-band gains, enable, sticky
// SAT/OVR flags and the combinational read mux.
module band_gain_regs #(
    parameter int NBANDS = eq_pkg::NBANDS,
    parameter int GW     = eq_pkg::GW
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 PSel,
    input  logic                 PEnable,
    input  logic                 PWrite,
    input  logic [31:0]          PAddr,
    input  logic [31:0]          PWData,
    output logic [31:0]          PRData,
    input  logic                 sat_set,
    input  logic                 ovr_set,
    input  logic [15:0]          mix_out,
    output logic                 en,
    output logic [NBANDS*GW-1:0] gains
);
    import eq_pkg::*;

    logic [GW-1:0] gain_q [NBANDS];
    logic          sat_q;
    logic          ovr_q;
    logic [3:0]    ofs;
    logic          gain_hit;
    logic          wr;
    logic          wr_ctrl;

    assign ofs      = PAddr[5:2];
    assign gain_hit = int'(ofs) < NBANDS;
    assign wr       = PSel & PEnable & PWrite;
    assign wr_ctrl  = wr && (ofs == CTRL_OFS);

    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < NBANDS; k++) gain_q[k] <= GAIN_RESET;
            en    <= 1'b0;
            sat_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            if (wr && gain_hit) gain_q[ofs] <= PWData[GW-1:0];
            if (wr_ctrl) en <= PWData[CTRL_EN];
            // hardware set wins over a simultaneous write-1-clear
            sat_q <= (sat_q & ~(wr_ctrl & PWData[CTRL_SAT])) | sat_set;
            ovr_q <= (ovr_q & ~(wr_ctrl & PWData[CTRL_OVR])) | ovr_set;
        end
    end

    // NOTE: PRData gets a default before any branch, so no latch is inferred.
    always_comb begin
        PRData = '0;
        if (PSel && !PWrite) begin
            if (gain_hit) begin
                PRData = 32'(gain_q[ofs]);
            end else if (ofs == CTRL_OFS) begin
                PRData[31:16]    = mix_out;
                PRData[CTRL_EN]  = en;
                PRData[CTRL_SAT] = sat_q;
                PRData[CTRL_OVR] = ovr_q;
            end
        end
    end

    for (genvar k = 0; k < NBANDS; k++) begin : g_flat
        assign gains[k*GW +: GW] = gain_q[k];
    end

endmodule

// File: rtl/band_gain_mixer.sv
// Per-band gain and summing stage: snapshots ten bands and their gains,
// accumulates the products on one multiplier, then rounds and saturates.
module band_gain_mixer #(
    parameter int NBANDS = eq_pkg::NBANDS,
    parameter int DW     = eq_pkg::DW,
    parameter int GW     = eq_pkg::GW,
    parameter int ACCW   = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 PSel,
    input  logic                 PEnable,
    input  logic                 PWrite,
    input  logic [31:0]          PAddr,
    input  logic [31:0]          PWData,
    output logic [31:0]          PRData,
    input  logic [NBANDS*DW-1:0] BandIn,
    input  logic                 SampleValid,
    output logic                 Busy,
    output logic [15:0]          MixOut,
    output logic                 MixValid
);
    import eq_pkg::*;

    localparam int IW = $clog2(NBANDS);
    localparam int PW = DW + GW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBANDS - 1);
    localparam logic signed [ACCW-1:0] OUT_MAX = 32767;
    localparam logic signed [ACCW-1:0] OUT_MIN = -32768;

    mix_state_t state_q, state_d;

    logic [IW-1:0]          idx_q;
    logic signed [ACCW-1:0] acc_q;
    logic signed [DW-1:0]   band_q [NBANDS];
    logic [GW-1:0]          gain_q [NBANDS];

    logic                   en;
    logic [NBANDS*GW-1:0]   gains;
    logic                   start;
    logic                   ovr_set;
    logic                   sat_set;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] rounded;
    logic [15:0]            sat_val;
    logic                   clip;

    band_gain_regs #(
        .NBANDS (NBANDS),
        .GW     (GW)
    ) u_regs (
        .Clk     (Clk),
        .Reset   (Reset),
        .PSel    (PSel),
        .PEnable (PEnable),
        .PWrite  (PWrite),
        .PAddr   (PAddr),
        .PWData  (PWData),
        .PRData  (PRData),
        .sat_set (sat_set),
        .ovr_set (ovr_set),
        .mix_out (MixOut),
        .en      (en),
        .gains   (gains)
    );

    assign start   = (state_q == ST_IDLE) && SampleValid && en;
    assign ovr_set = (state_q != ST_IDLE) && SampleValid && en;
    assign sat_set = (state_q == ST_ROUND) && clip;

    // gain is unsigned Q4.4; a zero sign bit keeps the product signed
    assign prod    = band_q[idx_q] * $signed({1'b0, gain_q[idx_q]});
    assign rounded = (acc_q + $signed(ACCW'(8))) >>> 4;

    always_comb begin
        sat_val = rounded[15:0];
        clip    = 1'b0;
        if (rounded > OUT_MAX) begin
            sat_val = 16'h7FFF;
            clip    = 1'b1;
        end else if (rounded < OUT_MIN) begin
            sat_val = 16'h8000;
            clip    = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_MAC;
            ST_MAC:   if (idx_q == LAST_IDX) state_d = ST_ROUND;
            ST_ROUND: state_d = ST_OUT;
            ST_OUT:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            MixOut  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx_q <= '0;
                        acc_q <= '0;
                    end
                end
                ST_MAC: begin
                    acc_q <= acc_q + ACCW'(prod);
                    idx_q <= idx_q + IW'(1);
                end
                ST_ROUND: MixOut <= sat_val;
                default: ;
            endcase
        end
    end

    // NOTE: snapshot registers carry no reset; they are always loaded on start before use.
    always_ff @(posedge Clk) begin
        if (start) begin
            for (int k = 0; k < NBANDS; k++) begin
                band_q[k] <= BandIn[k*DW +: DW];
                gain_q[k] <= gains[k*GW +: GW];
            end
        end
    end

    assign Busy     = (state_q != ST_IDLE);
    assign MixValid = (state_q == ST_OUT);

endmodule
